// File: rtl/axi_mem_responder_if.sv
// ============================================================================
// Module  : axi_mem_responder_if
// Brief   : AXI-style AW/W/B/AR/R bundle for the memory responder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface axi_mem_responder_if;
    logic                   AWVALID;
    logic                   AWREADY;
    logic [3:0]             AWID;
    logic [7:0]             AWLEN;
    logic [`ADDR_WIDTH-1:0] AWADDR;

    logic                   WVALID;
    logic                   WREADY;
    logic [3:0]             WID;
    logic [`DATA_WIDTH-1:0] WDATA;
    logic                   WLAST;

    logic                   BVALID;
    logic                   BREADY;
    logic [3:0]             BID;

    logic                   ARVALID;
    logic                   ARREADY;
    logic [3:0]             ARID;
    logic [7:0]             ARLEN;
    logic [`ADDR_WIDTH-1:0] ARADDR;

    logic                   RVALID;
    logic                   RREADY;
    logic [3:0]             RID;
    logic [`DATA_WIDTH-1:0] RDATA;
    logic                   RLAST;

    modport slave (
        input  AWVALID, AWID, AWLEN, AWADDR,
        output AWREADY,
        input  WVALID, WID, WDATA, WLAST,
        output WREADY,
        output BVALID, BID,
        input  BREADY,
        input  ARVALID, ARID, ARLEN, ARADDR,
        output ARREADY,
        output RVALID, RID, RDATA, RLAST,
        input  RREADY
    );

    modport master (
        output AWVALID, AWID, AWLEN, AWADDR,
        input  AWREADY,
        output WVALID, WID, WDATA, WLAST,
        input  WREADY,
        input  BVALID, BID,
        output BREADY,
        output ARVALID, ARID, ARLEN, ARADDR,
        input  ARREADY,
        input  RVALID, RID, RDATA, RLAST,
        output RREADY
    );
endinterface

`default_nettype wire

// File: rtl/axi_mem_responder.sv
// ============================================================================
// Module  : axi_mem_responder
// Brief   : Word-addressed memory behind independent AXI-style write and read
//           FSMs; optional read latency via macro MEM_READ_DELAY_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axi_mem_responder #(
    parameter int MEM_INDEX_WIDTH = 14,
    parameter int READ_DELAY      = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    axi_mem_responder_if.slave bus
);

    localparam int c_DEPTH = 2 ** MEM_INDEX_WIDTH;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

`ifdef MEM_READ_DELAY_EN
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DELAY = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;
`else
    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;
`endif

    logic [`DATA_WIDTH-1:0]     r_mem [c_DEPTH];

    w_state_t                   r_wstate;
    w_state_t                   w_wstate_nxt;
    logic [MEM_INDEX_WIDTH-1:0] r_widx;
    logic [7:0]                 r_wcnt;
    logic [3:0]                 r_bid;
    logic                       w_awready;
    logic                       w_wready;
    logic                       w_bvalid;
    logic                       w_mem_we;

    r_state_t                   r_rstate;
    r_state_t                   w_rstate_nxt;
    logic [MEM_INDEX_WIDTH-1:0] r_ridx;
    logic [MEM_INDEX_WIDTH-1:0] w_ar_idx;
    logic [MEM_INDEX_WIDTH-1:0] w_ridx_inc;
    logic [MEM_INDEX_WIDTH-1:0] w_rd_idx;
    logic [7:0]                 r_rcnt;
    logic [3:0]                 r_rid;
    logic [`DATA_WIDTH-1:0]     r_rdata;
    logic                       w_arready;
    logic                       w_rvalid;
    logic                       w_rd_en;
    logic                       w_unused_ok;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = 1'b1;
                if (bus.AWVALID) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                w_wready = 1'b1;
                // Burst ends on the beat count alone; WLAST is not consulted.
                if (bus.WVALID && (r_wcnt == 8'd1)) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (bus.BREADY) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_widx <= '0;
            r_wcnt <= '0;
            r_bid  <= '0;
        end else if (w_awready && bus.AWVALID) begin
            r_widx <= bus.AWADDR[MEM_INDEX_WIDTH+1:2];
            r_wcnt <= (bus.AWLEN == 8'd0) ? 8'd1 : bus.AWLEN;
            r_bid  <= bus.AWID;
        end else if (w_wready && bus.WVALID) begin
            r_widx <= r_widx + MEM_INDEX_WIDTH'(1);
            r_wcnt <= r_wcnt - 8'd1;
        end
    end

    assign w_mem_we = rst_n && w_wready && bus.WVALID;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_widx] <= bus.WDATA;
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    assign w_ar_idx   = bus.ARADDR[MEM_INDEX_WIDTH+1:2];
    assign w_ridx_inc = r_ridx + MEM_INDEX_WIDTH'(1);

`ifdef MEM_READ_DELAY_EN
    localparam int c_DLY_W = (READ_DELAY > 1) ? $clog2(READ_DELAY) : 1;
    logic [c_DLY_W-1:0] r_dly;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dly <= '0;
        end else if (w_arready && bus.ARVALID) begin
            r_dly <= c_DLY_W'(READ_DELAY - 1);
        end else if ((r_rstate == R_DELAY) && (r_dly != '0)) begin
            r_dly <= r_dly - c_DLY_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    // The storage read is issued one cycle before each beat is presented.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rvalid     = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_idx     = r_ridx;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (bus.ARVALID) begin
`ifdef MEM_READ_DELAY_EN
                    if (READ_DELAY == 0) begin
                        w_rstate_nxt = R_DATA;
                        w_rd_en      = 1'b1;
                        w_rd_idx     = w_ar_idx;
                    end else begin
                        w_rstate_nxt = R_DELAY;
                    end
`else
                    w_rstate_nxt = R_DATA;
                    w_rd_en      = 1'b1;
                    w_rd_idx     = w_ar_idx;
`endif
                end
            end
`ifdef MEM_READ_DELAY_EN
            R_DELAY: begin
                if (r_dly == '0) begin
                    w_rstate_nxt = R_DATA;
                    w_rd_en      = 1'b1;
                end
            end
`endif
            R_DATA: begin
                w_rvalid = 1'b1;
                if (bus.RREADY) begin
                    if (r_rcnt == 8'd1) begin
                        w_rstate_nxt = R_IDLE;
                    end else begin
                        w_rd_en  = 1'b1;
                        w_rd_idx = w_ridx_inc;
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ridx <= '0;
            r_rcnt <= '0;
            r_rid  <= '0;
        end else if (w_arready && bus.ARVALID) begin
            r_ridx <= w_ar_idx;
            r_rcnt <= (bus.ARLEN == 8'd0) ? 8'd1 : bus.ARLEN;
            r_rid  <= bus.ARID;
        end else if (w_rvalid && bus.RREADY) begin
            r_ridx <= w_ridx_inc;
            r_rcnt <= r_rcnt - 8'd1;
        end
    end

    // Non-blocking read gives the pre-write word on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_rd_en) begin
            r_rdata <= r_mem[w_rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.AWREADY = w_awready;
    assign bus.WREADY  = w_wready;
    assign bus.BVALID  = w_bvalid;
    assign bus.BID     = r_bid;
    assign bus.ARREADY = w_arready;
    assign bus.RVALID  = w_rvalid;
    assign bus.RID     = r_rid;
    assign bus.RDATA   = r_rdata;
    assign bus.RLAST   = w_rvalid && (r_rcnt == 8'd1);

    assign w_unused_ok = ^{bus.WID, bus.WLAST, bus.AWADDR, bus.ARADDR, (READ_DELAY != 0)};

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
// ============================================================================
// Module  : tb_axi_mem_responder
// Brief   : Directed table-driven bench for axi_mem_responder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_axi_mem_responder;

`ifdef MEM_READ_DELAY_EN
    localparam int          EXP_LAT = 5;
    localparam logic [31:0] EXP_RAW = 32'h2222_2222;
`else
    localparam int          EXP_LAT = 1;
    localparam logic [31:0] EXP_RAW = 32'h1111_1111;
`endif

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;

    axi_mem_responder_if bus ();

    axi_mem_responder #(
        .MEM_INDEX_WIDTH (14),
        .READ_DELAY      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        int          len;
        logic [3:0]  id;
        logic [31:0] dat;
        int          stall_beat;
        int          stall_cyc;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                            input logic [31:0] base, input string tag);
        int beats;
        int t;
        beats = (len == 0) ? 1 : len;
        bus.AWVALID = 1'b1;
        bus.AWADDR  = addr;
        bus.AWLEN   = 8'(len);
        bus.AWID    = id;
        t = 0;
        while (!bus.AWREADY && t < 100) begin tick(); t++; end
        chk($sformatf("%s.awready", tag), 32'(bus.AWREADY), 32'd1);
        tick();
        bus.AWVALID = 1'b0;
        for (int i = 0; i < beats; i++) begin
            bus.WVALID = 1'b1;
            bus.WDATA  = base + 32'(i);
            bus.WID    = id;
            bus.WLAST  = (i == beats - 1);
            t = 0;
            while (!bus.WREADY && t < 100) begin tick(); t++; end
            if (t >= 100) chk($sformatf("%s.wready[%0d]", tag, i), 32'(bus.WREADY), 32'd1);
            tick();
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        chk($sformatf("%s.bvalid", tag), 32'(bus.BVALID), 32'd1);
        chk($sformatf("%s.bid", tag), 32'(bus.BID), 32'(id));
        chk($sformatf("%s.awready_in_resp", tag), 32'(bus.AWREADY), 32'd0);
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        chk($sformatf("%s.bvalid_clear", tag), 32'(bus.BVALID), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input logic [31:0] exp_base, input int stall_beat,
                           input int stall_cyc, input string tag);
        int beats;
        int t;
        beats = (len == 0) ? 1 : len;
        bus.ARVALID = 1'b1;
        bus.ARADDR  = addr;
        bus.ARLEN   = 8'(len);
        bus.ARID    = id;
        t = 0;
        while (!bus.ARREADY && t < 100) begin tick(); t++; end
        chk($sformatf("%s.arready", tag), 32'(bus.ARREADY), 32'd1);
        tick();
        bus.ARVALID = 1'b0;
        t = 1;
        while (!bus.RVALID && t < 100) begin tick(); t++; end
        chk($sformatf("%s.rlat", tag), 32'(t), 32'(EXP_LAT));
        for (int i = 0; i < beats; i++) begin
            chk($sformatf("%s.rvalid[%0d]", tag, i), 32'(bus.RVALID), 32'd1);
            chk($sformatf("%s.rdata[%0d]", tag, i), bus.RDATA, exp_base + 32'(i));
            chk($sformatf("%s.rid[%0d]", tag, i), 32'(bus.RID), 32'(id));
            chk($sformatf("%s.rlast[%0d]", tag, i), 32'(bus.RLAST), 32'(i == beats - 1));
            if (i == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    tick();
                    chk($sformatf("%s.stall_rvalid[%0d]", tag, s), 32'(bus.RVALID), 32'd1);
                    chk($sformatf("%s.stall_rdata[%0d]", tag, s), bus.RDATA, exp_base + 32'(i));
                    chk($sformatf("%s.stall_rlast[%0d]", tag, s), 32'(bus.RLAST), 32'(i == beats - 1));
                end
            end
            bus.RREADY = 1'b1;
            tick();
            bus.RREADY = 1'b0;
        end
        chk($sformatf("%s.rvalid_done", tag), 32'(bus.RVALID), 32'd0);
        chk($sformatf("%s.arready_idle", tag), 32'(bus.ARREADY), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk($sformatf("%s.awready", tag), 32'(bus.AWREADY), 32'd1);
        chk($sformatf("%s.arready", tag), 32'(bus.ARREADY), 32'd1);
        chk($sformatf("%s.wready", tag), 32'(bus.WREADY), 32'd0);
        chk($sformatf("%s.bvalid", tag), 32'(bus.BVALID), 32'd0);
        chk($sformatf("%s.rvalid", tag), 32'(bus.RVALID), 32'd0);
        chk($sformatf("%s.rlast", tag), 32'(bus.RLAST), 32'd0);
        chk($sformatf("%s.bid", tag), 32'(bus.BID), 32'd0);
        chk($sformatf("%s.rid", tag), 32'(bus.RID), 32'd0);
        chk($sformatf("%s.rdata", tag), bus.RDATA, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.AWVALID = 1'b0; bus.AWID = '0; bus.AWLEN = '0; bus.AWADDR = '0;
        bus.WVALID  = 1'b0; bus.WID  = '0; bus.WDATA = '0; bus.WLAST  = 1'b0;
        bus.BREADY  = 1'b0;
        bus.ARVALID = 1'b0; bus.ARID = '0; bus.ARLEN = '0; bus.ARADDR = '0;
        bus.RREADY  = 1'b0;

        //            wr    addr          len id     dat           stall
        vecs[0] = '{1'b1, 32'h0000_0040, 4, 4'h0, 32'h0000_00A0, -1, 0};
        vecs[1] = '{1'b0, 32'h0000_0040, 4, 4'h8, 32'h0000_00A0, -1, 0};
        vecs[2] = '{1'b0, 32'h0000_0040, 4, 4'h5, 32'h0000_00A0,  1, 3};
        vecs[3] = '{1'b1, 32'h0000_FFFC, 2, 4'h2, 32'h0000_00B0, -1, 0};
        vecs[4] = '{1'b0, 32'h0000_FFFC, 2, 4'h1, 32'h0000_00B0, -1, 0};
        vecs[5] = '{1'b0, 32'h0000_0000, 1, 4'h6, 32'h0000_00B1, -1, 0};
        vecs[6] = '{1'b1, 32'h0000_0200, 4, 4'h9, 32'h0000_00C0, -1, 0};
        vecs[7] = '{1'b1, 32'h0001_0083, 0, 4'h7, 32'h0000_00D0, -1, 0};
        vecs[8] = '{1'b0, 32'h0000_0080, 0, 4'hF, 32'h0000_00D0, -1, 0};
        vecs[9] = '{1'b0, 32'h0000_0041, 3, 4'h3, 32'h0000_00A0, -1, 0};

        repeat (3) tick();
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("post_reset");

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].wr)
                do_write(vecs[v].addr, vecs[v].len, vecs[v].id, vecs[v].dat, $sformatf("vec%0d", v));
            else
                do_read(vecs[v].addr, vecs[v].len, vecs[v].id, vecs[v].dat,
                        vecs[v].stall_beat, vecs[v].stall_cyc, $sformatf("vec%0d", v));
        end

        // Concurrent write and read bursts to disjoint regions
        fork
            do_write(32'h0000_0100, 4, 4'hA, 32'h0000_00E0, "ovl_w");
            do_read (32'h0000_0200, 4, 4'hB, 32'h0000_00C0, -1, 0, "ovl_r");
        join
        do_read(32'h0000_0100, 4, 4'h4, 32'h0000_00E0, -1, 0, "ovl_chk");

        // Same-cycle write and read of one word
        do_write(32'h0000_0300, 1, 4'h3, 32'h1111_1111, "raw_pre");
        bus.AWVALID = 1'b1; bus.AWADDR = 32'h300; bus.AWLEN = 8'd1; bus.AWID = 4'h3;
        tick();
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b1; bus.WDATA = 32'h2222_2222; bus.WLAST = 1'b1;
        bus.ARVALID = 1'b1; bus.ARADDR = 32'h300; bus.ARLEN = 8'd1; bus.ARID = 4'h4;
        chk("raw.both_ready", 32'({bus.WREADY, bus.ARREADY}), 32'b11);
        tick();
        bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.ARVALID = 1'b0;
        chk("raw.bvalid", 32'(bus.BVALID), 32'd1);
        bus.BREADY = 1'b1;
        t = 1;
        while (!bus.RVALID && t < 100) begin tick(); t++; end
        bus.BREADY = 1'b0;
        chk("raw.rdata", bus.RDATA, EXP_RAW);
        chk("raw.rid", 32'(bus.RID), 32'h4);
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        do_read(32'h0000_0300, 1, 4'h4, 32'h2222_2222, -1, 0, "raw_post");

        // Reset during the second read beat
        bus.ARVALID = 1'b1; bus.ARADDR = 32'h40; bus.ARLEN = 8'd4; bus.ARID = 4'hC;
        tick();
        bus.ARVALID = 1'b0;
        t = 1;
        while (!bus.RVALID && t < 100) begin tick(); t++; end
        chk("rst.beat0", bus.RDATA, 32'h0000_00A0);
        bus.RREADY = 1'b1;
        tick();
        chk("rst.beat1", bus.RDATA, 32'h0000_00A1);
        bus.RREADY = 1'b0;
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("mid_burst_reset");
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("after_mid_reset");
        do_read(32'h0000_0040, 4, 4'hC, 32'h0000_00A0, -1, 0, "rst_readback");
        do_read(32'h0000_0000, 1, 4'h2, 32'h0000_00B1, -1, 0, "rst_wrapword");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
